// File: rtl/irig_frame_sync.sv
// IRIG-B pulse-width symbol parser with frame alignment; IRIG_DEBOUNCE_EN enables the input debouncer.
// Latency: debounce_din fall -> sym_valid 2 cycles; no backpressure, one symbol strobe per pulse.
module irig_frame_sync #(
    parameter int CNT_W       = 32,
    parameter int FRAME_LEN   = 100,
    parameter int MARK_PERIOD = 10,
    parameter int IDX_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [CNT_W-1:0] deb_cycles,
    input  logic [CNT_W-1:0] zero_max,
    input  logic [CNT_W-1:0] one_max,
    input  logic [CNT_W-1:0] id_max,
    output logic             debounce_din,
    output logic [1:0]       sym,
    output logic             sym_valid,
    output logic [IDX_W-1:0] sym_index,
    output logic             frame_start,
    output logic             locked,
    output logic [15:0]      err_count
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SEEN_P = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [1:0] SYM_ZERO = 2'd0;
    localparam logic [1:0] SYM_ONE  = 2'd1;
    localparam logic [1:0] SYM_MARK = 2'd2;
    localparam logic [1:0] SYM_ERR  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       din_m, din_s;
    logic [1:0] sync_fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_m     <= 1'b0;
            din_s     <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            din_m     <= din;
            din_s     <= din_m;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

`ifdef IRIG_DEBOUNCE_EN
    logic [CNT_W-1:0] deb_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt      <= '0;
            debounce_din <= 1'b0;
        end else if (din_s != debounce_din) begin
            if (deb_cnt >= deb_cycles) begin
                debounce_din <= din_s;
                deb_cnt      <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_ONE;
            end
        end else begin
            deb_cnt <= '0;
        end
    end
`else
    logic unused_deb_cycles;
    assign unused_deb_cycles = ^deb_cycles;

    always_ff @(posedge clk) begin
        if (rst) debounce_din <= 1'b0;
        else     debounce_din <= din_s;
    end
`endif

    logic             deb_q, armed, in_pulse;
    logic [CNT_W-1:0] width;
    logic             rise, fall;

    assign rise = debounce_din & ~deb_q;
    assign fall = ~debounce_din & deb_q;

    // A pulse already high when reset releases is never armed, so it cannot emit a partial symbol.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q    <= 1'b0;
            armed    <= 1'b0;
            in_pulse <= 1'b0;
            width    <= '0;
        end else begin
            deb_q <= debounce_din;
            if (sync_fill[1] && !din_s && !debounce_din)
                armed <= 1'b1;
            if (rise && armed)
                in_pulse <= 1'b1;
            else if (fall)
                in_pulse <= 1'b0;
            if (debounce_din)
                width <= rise ? CNT_ONE : ((width == CNT_MAX) ? width : width + CNT_ONE);
        end
    end

    logic [1:0] cls_now;

    always_comb begin
        cls_now = SYM_ERR;
        if (width <= zero_max)     cls_now = SYM_ZERO;
        else if (width <= one_max) cls_now = SYM_ONE;
        else if (width <= id_max)  cls_now = SYM_MARK;
    end

    logic       cls_vld;
    logic [1:0] cls_sym;

    always_ff @(posedge clk) begin
        if (rst) begin
            cls_vld <= 1'b0;
            cls_sym <= SYM_ZERO;
        end else begin
            cls_vld <= fall & in_pulse;
            if (fall && in_pulse)
                cls_sym <= cls_now;
        end
    end

    function automatic logic is_mark(input logic [IDX_W-1:0] n);
        return (n == '0) || ((32'(n) % MARK_PERIOD) == MARK_PERIOD - 1);
    endfunction

    logic [1:0]       state;
    logic [IDX_W-1:0] nidx;
    logic             cls_is_p, lock_bad;

    assign nidx     = (sym_index == IDX_W'(FRAME_LEN - 1)) ? '0 : sym_index + IDX_W'(1);
    assign cls_is_p = (cls_sym == SYM_MARK);
    assign lock_bad = (cls_sym == SYM_ERR) || (cls_is_p != is_mark(nidx));

    // sym_index doubles as the frame position register while locked.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_HUNT;
            sym         <= SYM_ZERO;
            sym_valid   <= 1'b0;
            sym_index   <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
        end else begin
            sym_valid   <= cls_vld;
            frame_start <= 1'b0;
            if (cls_vld) begin
                sym <= cls_sym;
                case (state)
                    ST_HUNT: begin
                        state     <= cls_is_p ? ST_SEEN_P : ST_HUNT;
                        sym_index <= '0;
                        locked    <= 1'b0;
                    end
                    ST_SEEN_P: begin
                        sym_index <= '0;
                        if (cls_is_p) begin
                            state       <= ST_LOCKED;
                            locked      <= 1'b1;
                            frame_start <= 1'b1;
                        end else begin
                            state  <= ST_HUNT;
                            locked <= 1'b0;
                        end
                    end
                    ST_LOCKED: begin
                        if (lock_bad) begin
                            state     <= ST_HUNT;
                            sym_index <= '0;
                            locked    <= 1'b0;
                            if (err_count != 16'hFFFF)
                                err_count <= err_count + 16'd1;
                        end else begin
                            sym_index   <= nidx;
                            locked      <= 1'b1;
                            frame_start <= (nidx == '0);
                        end
                    end
                    default: begin
                        state     <= ST_HUNT;
                        sym_index <= '0;
                        locked    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irig_frame_sync.sv
// Directed/randomized bench for irig_frame_sync against a symbol-level frame model.
module tb_irig_frame_sync;

    localparam int FRAME_LEN = 100;
`ifdef IRIG_DEBOUNCE_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] deb_cycles = 32'd3;
    logic [31:0] zero_max = 32'd30, one_max = 32'd60, id_max = 32'd90;

    logic        debounce_din, sym_valid, frame_start, locked;
    logic [1:0]  sym;
    logic [6:0]  sym_index;
    logic [15:0] err_count;

    irig_frame_sync dut (
        .clk(clk), .rst(rst), .din(din), .deb_cycles(deb_cycles),
        .zero_max(zero_max), .one_max(one_max), .id_max(id_max),
        .debounce_din(debounce_din), .sym(sym), .sym_valid(sym_valid),
        .sym_index(sym_index), .frame_start(frame_start), .locked(locked),
        .err_count(err_count)
    );

    logic        debounce_din2, sym_valid2, frame_start2, locked2;
    logic [1:0]  sym2;
    logic [6:0]  sym_index2;
    logic [15:0] err_count2;

    irig_frame_sync #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .din(din), .deb_cycles(8'd3),
        .zero_max(8'd30), .one_max(8'd60), .id_max(8'd254),
        .debounce_din(debounce_din2), .sym(sym2), .sym_valid(sym_valid2),
        .sym_index(sym_index2), .frame_start(frame_start2), .locked(locked2),
        .err_count(err_count2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  s;
        logic [6:0]  idx;
        logic        lk;
        logic        fs;
        logic [15:0] ec;
        int          at;
        int          dfall;
    } cap_t;

    cap_t       capq[$];
    int         deb_fall_cyc = 0;
    logic       deb_last = 1'b0;
    logic [1:0] sym2_last = 2'd0;
    int         n_sym2 = 0;

    always @(negedge clk) begin
        if (deb_last && !debounce_din) deb_fall_cyc = cyc;
        deb_last = debounce_din;
        if (sym_valid)
            capq.push_back('{sym, sym_index, locked, frame_start, err_count, cyc, deb_fall_cyc});
        if (sym_valid2) begin
            sym2_last = sym2;
            n_sym2++;
        end
    end

    int npass = 0, nchk = 0, nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: symbol-level frame alignment rules.
    logic m_locked = 1'b0, m_seenp = 1'b0, e_fs = 1'b0;
    int   m_idx = 0, m_err = 0;

    function automatic logic is_mark(input int n);
        return (n == 0) || (n % 10 == 9);
    endfunction

    function automatic logic [1:0] classify(input int w);
        if (w <= 30) return 2'd0;
        if (w <= 60) return 2'd1;
        if (w <= 90) return 2'd2;
        return 2'd3;
    endfunction

    task automatic model(input logic [1:0] s);
        int   n;
        logic bad;
        e_fs = 1'b0;
        if (m_locked) begin
            n   = (m_idx + 1) % FRAME_LEN;
            bad = (s == 2'd3) || ((s == 2'd2) != is_mark(n));
            if (bad) begin
                m_locked = 1'b0;
                m_seenp  = 1'b0;
                m_idx    = 0;
                if (m_err < 65535) m_err++;
            end else begin
                m_idx = n;
                e_fs  = (n == 0);
            end
        end else if (s == 2'd2 && m_seenp) begin
            m_locked = 1'b1;
            m_seenp  = 1'b0;
            m_idx    = 0;
            e_fs     = 1'b1;
        end else begin
            m_seenp = (s == 2'd2);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_seenp  = 1'b0;
        m_idx    = 0;
        m_err    = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_check(input string tag, input logic [1:0] s_exp, input int din_fall, input logic do_lat);
        cap_t c;
        for (int i = 0; i < 30 && capq.size() == 0; i++) tick(1);
        if (capq.size() == 0) begin
            nchk++;
            nfail++;
            $error("FAIL %s timeout: no sym_valid observed, required one", tag);
        end else begin
            c = capq.pop_front();
            model(s_exp);
            chk({tag, ".sym"}, c.s, s_exp);
            chk({tag, ".idx"}, c.idx, m_locked ? m_idx : 0);
            chk({tag, ".locked"}, c.lk, m_locked);
            chk({tag, ".frame_start"}, c.fs, e_fs);
            chk({tag, ".err_count"}, c.ec, m_err);
            if (do_lat) begin
                chk({tag, ".deb_lat"}, c.at - c.dfall, 2);
                chk({tag, ".din_lat"}, c.at - din_fall, LAT);
            end
        end
    endtask

    task automatic send_chk(input string tag, input int w);
        int f;
        din = 1'b1;
        tick(w);
        din = 1'b0;
        f = cyc;
        tick(12);
        pop_check(tag, classify(w), f, 1'b1);
    endtask

    task automatic send_idx(input int n);
        int w;
        if (is_mark(n))                 w = $urandom_range(90, 61);
        else if ($urandom_range(1, 0))  w = $urandom_range(60, 31);
        else                            w = $urandom_range(30, 5);
        send_chk($sformatf("frm%0d", n), w);
    endtask

    int base2;
    int pulses[] = '{20, 50, 80, 120, 30, 31, 60, 61, 91, 90, 45};

    initial begin
        rst = 1'b1;
        tick(3);
        chk("rst.debounce_din", debounce_din, 0);
        chk("rst.sym", sym, 0);
        chk("rst.sym_valid", sym_valid, 0);
        chk("rst.sym_index", sym_index, 0);
        chk("rst.frame_start", frame_start, 0);
        chk("rst.locked", locked, 0);
        chk("rst.err_count", err_count, 0);
        rst = 1'b0;
        tick(10);

        foreach (pulses[i]) send_chk($sformatf("w%0d", pulses[i]), pulses[i]);

        base2 = n_sym2;
        send_chk("w261", 261);
        chk("sat.count", n_sym2 - base2, 1);
        chk("sat.sym", sym2_last, 3);

        // Short low glitch inside a 50-cycle pulse.
        din = 1'b1; tick(24);
        din = 1'b0; tick(2);
        din = 1'b1; tick(24);
        din = 1'b0; tick(20);
`ifdef IRIG_DEBOUNCE_EN
        pop_check("glitch", classify(50), 0, 1'b0);
`else
        pop_check("glitch_a", classify(24), 0, 1'b0);
        pop_check("glitch_b", classify(24), 0, 1'b0);
`endif
        chk("glitch.extra", capq.size(), 0);

        // P0 then Pr, one full frame, into the next frame.
        send_chk("p0", 75);
        send_chk("pr", 75);
        for (int n = 1; n < FRAME_LEN; n++) send_idx(n);
        send_idx(0);
        for (int n = 1; n < 19; n++) send_idx(n);
        send_chk("bad19", 50);
        chk("bad19.err_model", m_err, 1);
        send_chk("relock_p0", 70);
        send_chk("relock_pr", 70);
        for (int n = 1; n <= 57; n++) send_idx(n);
        chk("pre_rst.idx", sym_index, 57);

        // Reset in the middle of a pulse.
        din = 1'b1;
        tick(40);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_reset();
        chk("mid.debounce_din", debounce_din, 0);
        chk("mid.sym", sym, 0);
        chk("mid.sym_valid", sym_valid, 0);
        chk("mid.sym_index", sym_index, 0);
        chk("mid.frame_start", frame_start, 0);
        chk("mid.locked", locked, 0);
        chk("mid.err_count", err_count, 0);
        tick(30);
        din = 1'b0;
        tick(25);
        chk("mid.discarded", capq.size(), 0);
        send_chk("post_rst", 80);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/irig_frame_sync.md
# irig_frame_sync

Parametrised successor to the IRIG-B pulse-width bit parser. Takes the raw IRIG-B DC-level input, optionally debounces it, measures every high pulse, classifies it as 0, 1, position marker (P) or error, then tracks frame alignment (double marker = frame reference) and emits each symbol with its position index. Sits between the GPS/IRIG input pin and the BCD time-field extractor.

## Interface
- `CNT_W`, 32: width of pulse-width counter and threshold ports.
- `FRAME_LEN`, 100: symbols per frame.
- `MARK_PERIOD`, 10: marker spacing; markers expected at index 0 and every index i with i % MARK_PERIOD == MARK_PERIOD-1.
- `IDX_W`, 7: width of `sym_index`; must satisfy 2^IDX_W >= FRAME_LEN.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  1  raw IRIG level, asynchronous.
- `deb_cycles`  in  CNT_W  debounce hold count.
- `zero_max`, `one_max`, `id_max`  in  CNT_W each  inclusive upper width bounds, in clk cycles, for 0, 1 and P.
- `debounce_din`  out  1  cleaned level.
- `sym`  out  2  0=zero, 1=one, 2=marker, 3=error.
- `sym_valid`  out  1  one-cycle strobe qualifying `sym`, `sym_index`.
- `sym_index`  out  IDX_W  position within frame; 0 when not locked.
- `frame_start`  out  1  one-cycle strobe with the index-0 marker.
- `locked`  out  1  frame alignment held.
- `err_count`  out  16  saturating count of lock losses.

## Operation
- `din` passes through a 2-flop synchroniser giving `din_s`.
- Pulse width w = number of cycles `debounce_din` is high. Counter loads 1 on the first high cycle, increments each further high cycle, saturates at 2^CNT_W-1.
- Classification on falling edge: w <= zero_max -> 0; zero_max < w <= one_max -> 1; one_max < w <= id_max -> 2; else 3. Thresholds sampled in the falling-edge cycle.
- Frame FSM, stepping once per classified symbol:
  - HUNT: marker -> SEEN_P; anything else -> stay.
  - SEEN_P: marker -> LOCKED, index 0, `frame_start`; else -> HUNT.
  - LOCKED: index = previous+1, wrapping FRAME_LEN-1 -> 0; `frame_start` at index 0.
  - LOCKED, lose lock -> HUNT: symbol 3, marker at a non-marker index, or non-marker at a marker index. That symbol is still emitted with `sym_index`=0 and `locked`=0. `err_count` +1, saturating at 0xFFFF.
- Third consecutive marker while in HUNT/SEEN_P (e.g. P0,Pr seen from HUNT): second marker locks; third is checked as index 1 -> lock loss.
- `sym_valid` pulses for every symbol in all states, including HUNT.

## Timing
- Reset values: `debounce_din`=0, `sym`=0, `sym_valid`=0, `sym_index`=0, `frame_start`=0, `locked`=0, `err_count`=0, FSM=HUNT, counters 0. `rst` mid-pulse discards the pulse; the next symbol needs a fresh rising edge.
- `din` -> `din_s`: 2 cycles.
- Debounce (macro on): `debounce_din` takes `din_s` once `din_s` has differed from `debounce_din` for deb_cycles+1 consecutive cycles. A shorter excursion is ignored and restarts the count.
- Falling edge observed at cycle t (`debounce_din` 1 at t-1, 0 at t) -> `sym`, `sym_valid`, `sym_index`, `frame_start`, `locked` update at t+2. `sym`/`sym_index` hold until the next strobe.
- Rising edge in the same cycle as `sym_valid`: both are processed, with no lost symbol.

## Configuration
- `IRIG_DEBOUNCE_EN` defined: debouncer as above.
- Not defined: `debounce_din` = `din_s` registered once (3 cycles from `din`), and `deb_cycles` is ignored.

## Test plan
Common setup: thresholds zero_max=30, one_max=60, id_max=90; deb_cycles=3, macro on.
- Pulses of 20, 50, 80, 120 high cycles -> `sym` 0, 1, 2, 3. Each `sym_valid` falls 2 cycles after the `debounce_din` fall. `locked`=0.
- 2-cycle low glitch inside a 50-cycle pulse -> `debounce_din` stays high, single symbol 1. Macro off -> two symbols of code 0.
- Full legal frame preceded by a P0 marker -> `locked`=1 with `frame_start` at Pr. Index runs 0..99, then `frame_start` again on the next frame's Pr at index 0, `err_count`=0.
- Locked, 50-cycle pulse at index 19 -> `locked`=0, `err_count`=1. Relock after the next two consecutive markers.
- Pulse of 2^CNT_W+5 cycles with CNT_W=8 -> width saturates at 255, `sym`=3.
- `rst` asserted at index 57 mid-pulse -> all outputs 0 the following cycle. The next 80-cycle pulse is emitted in HUNT.
